// File: rtl/eval_sequencer_pkg.sv
// eval_sequencer_pkg: shared board width, sequencer states and round-robin grant helper
package eval_sequencer_pkg;

    localparam int BOARD_WIDTH = 256;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        ATTACK_WAIT,
        EVAL,
        EVAL_WAIT,
        CLEAR,
        RESPOND
    } seq_state_t;

    function automatic logic rr_grant(input logic [1:0] req, input logic ptr);
        return req[ptr] ? ptr : ~ptr;
    endfunction

endpackage

// File: rtl/eval_sequencer_rr_arb2.sv
// rr_arb2: two-way round-robin grant, pointer moves to the loser on every accept
module rr_arb2
    import eval_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic ptr;

    always_comb begin
        gnt_idx = rr_grant(req, ptr);
        gnt     = req & {gnt_idx, ~gnt_idx};
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= 1'b0;
        else if (accept)
            ptr <= ~gnt_idx;
    end

endmodule

// File: rtl/eval_sequencer.sv
// eval_sequencer: arbitrates two requesters onto one board_attack/evaluate pair and returns tagged scores
module eval_sequencer
    import eval_sequencer_pkg::*;
#(
    parameter int EVAL_WIDTH     = 24,
    parameter int UCI_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   req_valid,
    output logic [1:0]                   req_ready,
    input  logic [BOARD_WIDTH-1:0]       req_board0,
    input  logic [BOARD_WIDTH-1:0]       req_board1,
    input  logic [1:0]                   req_wtm,
    input  logic [3:0]                   req_castle0,
    input  logic [3:0]                   req_castle1,
    input  logic [UCI_WIDTH-1:0]         req_uci0,
    input  logic [UCI_WIDTH-1:0]         req_uci1,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_id,
    output logic signed [EVAL_WIDTH-1:0] rsp_eval,
    output logic                         rsp_insufficient,
    output logic                         rsp_white_in_check,
    output logic                         rsp_black_in_check,
    output logic                         rsp_timeout,
    output logic [BOARD_WIDTH-1:0]       dp_board,
    output logic                         dp_wtm,
    output logic [3:0]                   dp_castle,
    output logic [UCI_WIDTH-1:0]         dp_uci,
    output logic                         attack_board_valid,
    output logic                         attack_clear,
    input  logic                         attack_done,
    input  logic                         white_in_check,
    input  logic                         black_in_check,
    output logic                         eval_board_valid,
    output logic                         eval_clear,
    input  logic                         eval_valid,
    input  logic signed [EVAL_WIDTH-1:0] eval_in,
    input  logic                         insufficient_material
);

    seq_state_t state, state_next;
    logic [1:0] gnt;
    logic gnt_idx, accept, waiting, wd_hit, timeout_hit;
    logic [TIMEOUT_WIDTH-1:0] wd;
    logic id_q, wic_q, bic_q, ins_q, to_q;
    logic signed [EVAL_WIDTH-1:0] eval_q;

    assign accept  = state == IDLE && |req_valid;
    assign waiting = state == ATTACK_WAIT || state == EVAL_WAIT;
    // wd_hit means the counter reaches TIMEOUT_CYCLES at this edge
    assign wd_hit  = wd == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    assign timeout_hit = wd_hit && ((state == ATTACK_WAIT && !attack_done) ||
                                    (state == EVAL_WAIT && !eval_valid));

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .accept  (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next         = state;
        req_ready          = 2'b00;
        attack_board_valid = 1'b0;
        eval_board_valid   = 1'b0;
        attack_clear       = 1'b0;
        eval_clear         = 1'b0;
        rsp_valid          = 1'b0;
        case (state)
            IDLE: begin
                req_ready  = gnt;
                state_next = accept ? ATTACK : IDLE;
            end
            ATTACK: begin
                attack_board_valid = 1'b1;
                state_next         = ATTACK_WAIT;
            end
            ATTACK_WAIT: state_next = attack_done ? EVAL : timeout_hit ? CLEAR : ATTACK_WAIT;
            EVAL: begin
                eval_board_valid = 1'b1;
                state_next       = EVAL_WAIT;
            end
            EVAL_WAIT: state_next = (eval_valid || timeout_hit) ? CLEAR : EVAL_WAIT;
            CLEAR: begin
                attack_clear = 1'b1;
                eval_clear   = 1'b1;
                state_next   = RESPOND;
            end
            RESPOND: begin
                rsp_valid  = 1'b1;
                state_next = rsp_ready ? IDLE : RESPOND;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_board  <= '0;
            dp_wtm    <= 1'b0;
            dp_castle <= '0;
            dp_uci    <= '0;
            id_q      <= 1'b0;
            wic_q     <= 1'b0;
            bic_q     <= 1'b0;
            ins_q     <= 1'b0;
            to_q      <= 1'b0;
            eval_q    <= '0;
            wd        <= '0;
        end else begin
            if (accept) begin
                dp_board  <= gnt_idx ? req_board1 : req_board0;
                dp_wtm    <= req_wtm[gnt_idx];
                dp_castle <= gnt_idx ? req_castle1 : req_castle0;
                dp_uci    <= gnt_idx ? req_uci1 : req_uci0;
                id_q      <= gnt_idx;
                wic_q     <= 1'b0;
                bic_q     <= 1'b0;
                ins_q     <= 1'b0;
                to_q      <= 1'b0;
                eval_q    <= '0;
            end
            wd <= !waiting ? '0 : (wd == TIMEOUT_WIDTH'(TIMEOUT_CYCLES)) ? wd : wd + TIMEOUT_WIDTH'(1);
            if (state == ATTACK_WAIT && attack_done) begin
                wic_q <= white_in_check;
                bic_q <= black_in_check;
            end
            if (state == EVAL_WAIT && eval_valid) begin
                eval_q <= eval_in;
                ins_q  <= insufficient_material;
            end
            // an aborted job reports no partial results
            if (timeout_hit) begin
                to_q   <= 1'b1;
                wic_q  <= 1'b0;
                bic_q  <= 1'b0;
                ins_q  <= 1'b0;
                eval_q <= '0;
            end
        end
    end

    assign rsp_id             = rsp_valid & id_q;
    assign rsp_eval           = rsp_valid ? eval_q : '0;
    assign rsp_insufficient   = rsp_valid & ins_q;
    assign rsp_white_in_check = rsp_valid & wic_q;
    assign rsp_black_in_check = rsp_valid & bic_q;
    assign rsp_timeout        = rsp_valid & to_q;

endmodule
